mem_port_arbiter: RTL

- Shares the single backing-memory port between the instruction cache (read-only refill requester, I-side) and the data cache (refill and write-back requester, D-side).
- Serialises one memory transaction at a time and holds the memory address, data and write enable stable for the whole transaction.
- Arbitrates ties round-robin, times out a hung memory access, and returns read data plus a one-cycle acknowledge to the winner.
- Sits between the cache miss paths (mrden/mwren, m_rd_address/m_wr_address) and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signal bundle for the shared memory port arbiter.
// slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic [1:0]    grant;
    logic          err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, grant, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, grant, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and D-cache refill/write-back.
// Latency: req sampled at edge N -> m_en cycle N+1 -> ack earliest cycle N+3; watchdog aborts after TIMEOUT wait cycles.
// Backpressure: no queueing; requesters hold req until their one-cycle ack, losers are re-arbitrated at next IDLE.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_d_q, last_d_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic          m_we_q, m_we_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [3:0]    wd_q, wd_d;
    logic          m_en_q, m_en_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] cap_d;
    logic          to_d;
    logic          pick_i, pick_d;

    // last_d_q = 1 means the D-side owned the port last, so I wins a tie
    assign pick_i = bus.i_req && (!bus.d_req || last_d_q);
    assign pick_d = bus.d_req && !pick_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_d_q  <= 1'b1;
            m_addr_q  <= '0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            wd_q      <= 4'd0;
            m_en_q    <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_d_q  <= last_d_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            wd_q      <= wd_d;
            m_en_q    <= m_en_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d_d  = last_d_q;
        m_addr_d  = m_addr_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;
        wd_d      = wd_q;
        cap_d     = '0;
        to_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_i) begin
                    state_d   = ISSUE;
                    grant_d   = 2'b01;
                    last_d_d  = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_we_d    = 1'b0;
                    m_wdata_d = '0;
                end else if (pick_d) begin
                    state_d   = ISSUE;
                    grant_d   = 2'b10;
                    last_d_d  = 1'b1;
                    m_addr_d  = bus.d_addr;
                    m_we_d    = bus.d_we;
                    m_wdata_d = bus.d_wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = 4'd0;
            end
            WAIT: begin
                // a completion in the same cycle as expiry still counts as a good access
                if (bus.m_ready) begin
                    state_d = RESP;
                    cap_d   = m_we_q ? '0 : bus.m_rdata;
                end else if (wd_q == 4'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    wd_d    = 4'(TIMEOUT);
                    to_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 4'd1;
                end
            end
            RESP: begin
                state_d   = IDLE;
                grant_d   = 2'b00;
                m_addr_d  = '0;
                m_we_d    = 1'b0;
                m_wdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_en_d    = (state_d == ISSUE);
        i_ack_d   = (state_d == RESP) && (state_q == WAIT) && grant_q[0];
        d_ack_d   = (state_d == RESP) && (state_q == WAIT) && grant_q[1];
        i_rdata_d = i_ack_d ? cap_d : '0;
        d_rdata_d = d_ack_d ? cap_d : '0;
        err_d     = (state_d == RESP) && to_d;
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.grant   = grant_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;
endmodule
